// File: rtl/read_latency_stats.sv
// Latency statistics collector: accumulates min/max/sum/count/errors over a configured
// run of probe samples. Optional histogram enabled by defining LATENCY_HIST_EN.
module read_latency_stats #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned HIST_BINS  = 16,
    parameter int unsigned HIST_SHIFT = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [31:0]                  cfg_num_samples,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [WIDTH-1:0]             in_latency,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_min,
    output logic [WIDTH-1:0]             out_max,
    output logic [63:0]                  out_sum,
    output logic [31:0]                  out_count,
    output logic [31:0]                  out_errors,
    output logic                         out_valid,
`ifdef LATENCY_HIST_EN
    input  logic [$clog2(HIST_BINS)-1:0] hist_rd_addr,
    output logic [31:0]                  hist_rd_data,
`endif
    input  logic                         out_ready
);

`ifdef LATENCY_HIST_EN
    typedef enum logic [1:0] {StIdle, StClear, StCollect, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [31:0]       num_q;
    logic [WIDTH-1:0]  min_q, max_q;
    logic [63:0]       sum_q;
    logic [31:0]       count_q, errors_q;
    logic              seen_q;
    logic              cfg_fire, in_fire, last_sample;

    assign cfg_ready   = (state_q == StIdle);
    assign in_ready    = (state_q == StCollect);
    assign out_valid   = (state_q == StDone);
    assign cfg_fire    = cfg_valid & cfg_ready;
    assign in_fire     = in_valid & in_ready;
    assign last_sample = ((count_q + 32'd1) == num_q);

    // min_q idles at all-ones until a nonzero sample arrives; seen_q masks it.
    assign out_min    = seen_q ? min_q : '0;
    assign out_max    = max_q;
    assign out_sum    = sum_q;
    assign out_count  = count_q;
    assign out_errors = errors_q;

`ifdef LATENCY_HIST_EN
    localparam int unsigned BinW = $clog2(HIST_BINS);
    localparam logic [BinW-1:0] LastBin = BinW'(HIST_BINS - 1);

    logic [31:0]      hist_q [HIST_BINS];
    logic [BinW-1:0]  clr_idx_q;
    logic [WIDTH-1:0] shifted;
    logic [BinW-1:0]  bin;
    logic [31:0]      hist_rd_data_q;

    assign shifted      = in_latency >> HIST_SHIFT;
    assign bin          = (shifted > WIDTH'(HIST_BINS - 1)) ? LastBin : shifted[BinW-1:0];
    assign hist_rd_data = hist_rd_data_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(HIST_BINS); i++) begin
                hist_q[i] <= '0;
            end
            clr_idx_q      <= '0;
            hist_rd_data_q <= '0;
        end else begin
            hist_rd_data_q <= hist_q[hist_rd_addr];
            if (cfg_fire) begin
                clr_idx_q <= '0;
            end else if (state_q == StClear) begin
                hist_q[clr_idx_q] <= '0;
                clr_idx_q         <= clr_idx_q + 1'b1;
            end else if (in_fire && (in_latency != '0) && (hist_q[bin] != 32'hFFFF_FFFF)) begin
                hist_q[bin] <= hist_q[bin] + 32'd1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
`ifdef LATENCY_HIST_EN
                    state_d = StClear;
`else
                    state_d = (cfg_num_samples == 32'd0) ? StDone : StCollect;
`endif
                end
            end
`ifdef LATENCY_HIST_EN
            StClear: begin
                if (clr_idx_q == LastBin) begin
                    state_d = (num_q == 32'd0) ? StDone : StCollect;
                end
            end
`endif
            StCollect: begin
                if (in_valid && last_sample) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            num_q    <= '0;
            min_q    <= '0;
            max_q    <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            errors_q <= '0;
            seen_q   <= 1'b0;
        end else if (cfg_fire) begin
            num_q    <= cfg_num_samples;
            min_q    <= '1;
            max_q    <= '0;
            sum_q    <= '0;
            count_q  <= '0;
            errors_q <= '0;
            seen_q   <= 1'b0;
        end else if (in_fire) begin
            count_q <= count_q + 32'd1;
            if (in_latency == '0) begin
                errors_q <= errors_q + 32'd1;
            end else begin
                seen_q <= 1'b1;
                sum_q  <= sum_q + 64'(in_latency);
                if (in_latency < min_q) begin
                    min_q <= in_latency;
                end
                if (in_latency > max_q) begin
                    max_q <= in_latency;
                end
            end
        end
    end

endmodule

// File: tb/tb_read_latency_stats.sv
// Scoreboard bench for read_latency_stats: expected summaries are queued by the stimulus
// and checked by a monitor on each out_valid/out_ready handshake.
module tb_read_latency_stats;

    localparam int HB = 16;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] cfg_num_samples;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] in_latency;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_min, out_max;
    logic [63:0] out_sum;
    logic [31:0] out_count, out_errors;
    logic        out_valid;
    logic        out_ready;
`ifdef LATENCY_HIST_EN
    logic [3:0]  hist_rd_addr;
    logic [31:0] hist_rd_data;
`endif

    read_latency_stats #(.WIDTH(32), .HIST_BINS(HB), .HIST_SHIFT(2)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .cfg_num_samples (cfg_num_samples),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .in_latency      (in_latency),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_min         (out_min),
        .out_max         (out_max),
        .out_sum         (out_sum),
        .out_count       (out_count),
        .out_errors      (out_errors),
        .out_valid       (out_valid),
`ifdef LATENCY_HIST_EN
        .hist_rd_addr    (hist_rd_addr),
        .hist_rd_data    (hist_rd_data),
`endif
        .out_ready       (out_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [63:0] sum;
        logic [31:0] cnt;
        logic [31:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic [31:0] mn, input logic [31:0] mx,
                                input logic [63:0] sum, input logic [31:0] cnt,
                                input logic [31:0] err);
        exp_t e;
        e.mn = mn; e.mx = mx; e.sum = sum; e.cnt = cnt; e.err = err;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: compares each consumed summary beat against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_beat");
            end else begin
                e = exp_q.pop_front();
                check("beat_min",    64'(out_min),    64'(e.mn));
                check("beat_max",    64'(out_max),    64'(e.mx));
                check("beat_sum",    out_sum,         e.sum);
                check("beat_count",  64'(out_count),  64'(e.cnt));
                check("beat_errors", 64'(out_errors), 64'(e.err));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_cfg(input logic [31:0] n);
        int t = 0;
        cfg_num_samples = n;
        cfg_valid       = 1'b1;
        while (!cfg_ready && t < 100) begin cyc(); t++; end
        if (!cfg_ready) fail_now("cfg_timeout");
        cyc();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input logic [31:0] s);
        int t = 0;
        in_latency = s;
        in_valid   = 1'b1;
        while (!in_ready && t < 100) begin cyc(); t++; end
        if (!in_ready) fail_now("send_timeout");
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        int t = 0;
        while (!out_valid && t < 200) begin cyc(); t++; end
        if (!out_valid) fail_now("out_valid_timeout");
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    // Configure, stream k samples back-to-back, check 1-cycle out_valid latency.
    task automatic run(input logic [31:0] n, input logic [31:0] s[4], input int k,
                       input exp_t e, input logic do_consume);
        exp_q.push_back(e);
        do_cfg(n);
        for (int i = 0; i < k; i++) begin
            if (i == k - 1) check("valid_before_last", 64'(out_valid), 64'd0);
            send(s[i]);
        end
        check("valid_after_last", 64'(out_valid), 64'd1);
        if (do_consume) consume();
    endtask

    task automatic wait_done_count(output int waited, output logic saw_in_ready);
        waited       = 0;
        saw_in_ready = 1'b0;
        while (!out_valid && waited < 100) begin
            if (in_ready) saw_in_ready = 1'b1;
            cyc();
            waited++;
        end
    endtask

    initial begin
        int   waited;
        logic saw;
        resetn          = 1'b0;
        cfg_valid       = 1'b0;
        cfg_num_samples = '0;
        in_valid        = 1'b0;
        in_latency      = '0;
        out_ready       = 1'b0;
`ifdef LATENCY_HIST_EN
        hist_rd_addr    = '0;
`endif
        cyc(); cyc();
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count",     64'(out_count), 64'd0);
        check("rst_sum",       out_sum,        64'd0);
        resetn = 1'b1;
        cyc();

        run(32'd4, '{32'd10, 32'd20, 32'd5, 32'd40}, 4, mk(5, 40, 75, 4, 0), 1'b1);
        run(32'd3, '{32'd7, 32'd0, 32'd9, 32'd0}, 3, mk(7, 9, 16, 3, 1), 1'b1);
        run(32'd2, '{32'd0, 32'd0, 32'd0, 32'd0}, 2, mk(0, 0, 0, 2, 2), 1'b1);

        // N = 0: goes straight to DONE (after the histogram clear if present).
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        do_cfg(32'd0);
        wait_done_count(waited, saw);
`ifdef LATENCY_HIST_EN
        check("n0_wait", 64'(waited), 64'(HB));
`else
        check("n0_wait", 64'(waited), 64'd0);
`endif
        check("n0_in_ready_seen", 64'(saw), 64'd0);
        consume();

        // Stalled summary: hold out_ready low with an extra sample pending.
        run(32'd2, '{32'd8, 32'd3, 32'd0, 32'd0}, 2, mk(3, 8, 11, 2, 0), 1'b0);
        in_latency = 32'd99;
        in_valid   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_min",       64'(out_min),   64'd3);
            check("stall_max",       64'(out_max),   64'd8);
            check("stall_sum",       out_sum,        64'd11);
            check("stall_count",     64'(out_count), 64'd2);
            check("stall_valid",     64'(out_valid), 64'd1);
            check("stall_cfg_ready", 64'(cfg_ready), 64'd0);
            check("stall_in_ready",  64'(in_ready),  64'd0);
            cyc();
        end
        in_valid = 1'b0;
        consume();
        check("post_ready_cfg_ready", 64'(cfg_ready), 64'd1);
        check("post_ready_out_valid", 64'(out_valid), 64'd0);

        // Reset mid-run discards the partial accumulation immediately.
        do_cfg(32'd5);
        send(32'd30);
        send(32'd50);
        check("pre_rst_count", 64'(out_count), 64'd2);
        resetn = 1'b0;
        #1;
        check("mid_rst_count",     64'(out_count), 64'd0);
        check("mid_rst_max",       64'(out_max),   64'd0);
        check("mid_rst_sum",       out_sum,        64'd0);
        check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("mid_rst_in_ready",  64'(in_ready),  64'd0);
        cyc();
        resetn = 1'b1;
        cyc();
        run(32'd1, '{32'd12, 32'd0, 32'd0, 32'd0}, 1, mk(12, 12, 12, 1, 0), 1'b1);

`ifdef LATENCY_HIST_EN
        run(32'd4, '{32'd3, 32'd4, 32'd100, 32'd0}, 4, mk(3, 100, 107, 4, 1), 1'b0);
        for (int i = 0; i < HB; i++) begin
            hist_rd_addr = 4'(i);
            cyc();
            check($sformatf("hist_bin%0d", i), 64'(hist_rd_data),
                  (i == 0 || i == 1 || i == HB - 1) ? 64'd1 : 64'd0);
        end
        consume();
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        do_cfg(32'd0);
        wait_done_count(waited, saw);
        for (int i = 0; i < HB; i++) begin
            hist_rd_addr = 4'(i);
            cyc();
            check($sformatf("hist2_bin%0d", i), 64'(hist_rd_data), 64'd0);
        end
        consume();
`endif

        cyc();
        check("beats_left", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
